// File: rtl/ac_actuator_seq.sv
// Actuator sequencer for the AC controller: fan pre-purge, minimum run time,
// fan overrun and anti-short-cycle lockout between heat/cool requests and hardware.
// Optional feature macro: AC_ACT_START_CNT_EN adds a saturating start_count output.
module ac_actuator_seq #(
   parameter int CNT_W    = 8,
   parameter int PRE_CYC  = 4,
   parameter int MIN_ON   = 16,
   parameter int POST_CYC = 8,
   parameter int MIN_OFF  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        heating,
   input  logic        cooling,
   output logic        fan,
   output logic        heater_en,
   output logic        compressor_en,
   output logic        conflict,
   output logic [2:0]  seq_state
`ifdef AC_ACT_START_CNT_EN
   ,
   output logic [15:0] start_count
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_HEAT = 3'd2,
      ST_COOL = 3'd3,
      ST_POST = 3'd4,
      ST_LOCK = 3'd5
   } state_t;

   // Last timer value of each timed state (timer counts 0..N-1)
   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYC - 1);
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CYC - 1);
   localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF - 1);
   localparam logic [CNT_W-1:0] TMR_MAX   = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             target_q, target_d;   // 0 = heat, 1 = cool
   logic             tgt_req;

   logic             fan_q, heater_q, comp_q, conflict_q;
   logic             fan_d, heater_d, comp_d, conflict_d;

   // Request line belonging to the start that is in progress
   assign tgt_req = target_q ? cooling : heating;

   // State register: FSM state, dwell timer and latched target
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         target_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         target_q <= target_d;
      end
   end

   // Next-state logic: sequencing and dwell timing
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      case (state_q)
         ST_IDLE: begin
            if (heating && !cooling) begin
               state_d  = ST_PRE;
               target_d = 1'b0;
            end else if (cooling && !heating) begin
               state_d  = ST_PRE;
               target_d = 1'b1;
            end
         end
         ST_PRE: begin
            // A dropped request aborts the purge straight into overrun
            if (!tgt_req)
               state_d = ST_POST;
            else if (timer_q == PRE_LAST)
               state_d = target_q ? ST_COOL : ST_HEAT;
         end
         ST_HEAT: begin
            if (timer_q >= ON_LAST && !heating)
               state_d = ST_POST;
         end
         ST_COOL: begin
            if (timer_q >= ON_LAST && !cooling)
               state_d = ST_POST;
         end
         ST_POST: begin
            if (timer_q == POST_LAST)
               state_d = ST_LOCK;
         end
         ST_LOCK: begin
            if (timer_q == OFF_LAST)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Timer restarts on every state change and saturates while dwelling
      if (state_d != state_q)
         timer_d = '0;
      else if (timer_q == TMR_MAX)
         timer_d = timer_q;
      else
         timer_d = timer_q + 1'b1;
   end

   // Output decode from the current state
   always_comb begin
      fan_d      = 1'b0;
      heater_d   = 1'b0;
      comp_d     = 1'b0;
      conflict_d = 1'b0;
      case (state_q)
         ST_PRE:  fan_d = 1'b1;
         ST_HEAT: begin
            fan_d    = 1'b1;
            heater_d = 1'b1;
         end
         ST_COOL: begin
            fan_d  = 1'b1;
            comp_d = 1'b1;
         end
         ST_POST: fan_d = 1'b1;
         ST_IDLE: conflict_d = heating && cooling;
         default: ;
      endcase
   end

   // Output registers: actuators switch one cycle after the state does
   always_ff @(posedge clk) begin
      if (rst) begin
         fan_q      <= 1'b0;
         heater_q   <= 1'b0;
         comp_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         fan_q      <= fan_d;
         heater_q   <= heater_d;
         comp_q     <= comp_d;
         conflict_q <= conflict_d;
      end
   end

   assign fan           = fan_q;
   assign heater_en     = heater_q;
   assign compressor_en = comp_q;
   assign conflict      = conflict_q;
   assign seq_state     = state_q;

`ifdef AC_ACT_START_CNT_EN
   logic [15:0] start_cnt_q;
   logic        start_pulse;

   assign start_pulse = (state_q == ST_PRE) &&
                        ((state_d == ST_HEAT) || (state_d == ST_COOL));

   // Count completed purges that started heating or cooling, saturating
   always_ff @(posedge clk) begin
      if (rst)
         start_cnt_q <= '0;
      else if (start_pulse && (start_cnt_q != 16'hFFFF))
         start_cnt_q <= start_cnt_q + 16'd1;
   end

   assign start_count = start_cnt_q;
`endif

endmodule

// File: tb/tb_ac_actuator_seq.sv
// Bench for ac_actuator_seq: directed request sequences with hand-derived
// per-cycle expectations, queued by the driver and checked by a monitor.
module tb_ac_actuator_seq;

   logic        clk = 1'b0;
   logic        rst, heating, cooling;
   logic        fan, heater_en, compressor_en, conflict;
   logic [2:0]  seq_state;
   logic [15:0] act_sc;
`ifdef AC_ACT_START_CNT_EN
   logic [15:0] start_count;
`endif

   ac_actuator_seq dut (
      .clk           (clk),
      .rst           (rst),
      .heating       (heating),
      .cooling       (cooling),
      .fan           (fan),
      .heater_en     (heater_en),
      .compressor_en (compressor_en),
      .conflict      (conflict),
      .seq_state     (seq_state)
`ifdef AC_ACT_START_CNT_EN
      ,
      .start_count   (start_count)
`endif
   );

`ifdef AC_ACT_START_CNT_EN
   assign act_sc = start_count;
`else
   assign act_sc = 16'd0;
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  o;    // {fan, heater_en, compressor_en}
      logic        cf;
      logic [2:0]  st;
      logic [15:0] sc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e_mon;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_sc = 16'd0;

   // n cycles of fixed inputs; each post-edge output is expected to be as given
   task automatic seg(input int n, input logic r, input logic h, input logic c,
                      input logic [2:0] o, input logic cf, input logic [2:0] st);
      for (int i = 0; i < n; i++) begin
         rst     = r;
         heating = h;
         cooling = c;
         @(posedge clk);
         exp_q.push_back({o, cf, st, exp_sc});
         @(negedge clk);
      end
   endtask

   // Full heat cycle from IDLE: heating held 8 cycles then dropped
   task automatic heat_cycle();
      seg(1,  0, 1, 0, 3'b000, 0, 3'd1);
      seg(3,  0, 1, 0, 3'b100, 0, 3'd1);
      exp_sc = exp_sc + 16'd1;
      seg(1,  0, 1, 0, 3'b100, 0, 3'd2);
      seg(3,  0, 1, 0, 3'b110, 0, 3'd2);
      seg(12, 0, 0, 0, 3'b110, 0, 3'd2);
      seg(1,  0, 0, 0, 3'b110, 0, 3'd4);
      seg(7,  0, 0, 0, 3'b100, 0, 3'd4);
      seg(1,  0, 0, 0, 3'b100, 0, 3'd5);
      seg(15, 0, 0, 0, 3'b000, 0, 3'd5);
      seg(1,  0, 0, 0, 3'b000, 0, 3'd0);
      seg(3,  0, 0, 0, 3'b000, 0, 3'd0);
   endtask

   // Monitor: compare every post-edge sample against the next queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            checks++;
            if ({fan, heater_en, compressor_en} !== e_mon.o || conflict !== e_mon.cf ||
                seq_state !== e_mon.st
`ifdef AC_ACT_START_CNT_EN
                || act_sc !== e_mon.sc
`endif
               ) begin
               errors++;
               $display("FAIL cycle_check #%0d t=%0t: got fhc=%b cf=%b st=%0d sc=%0d, expected fhc=%b cf=%b st=%0d sc=%0d",
                        checks, $time, {fan, heater_en, compressor_en}, conflict, seq_state, act_sc,
                        e_mon.o, e_mon.cf, e_mon.st, e_mon.sc);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; heating = 1'b0; cooling = 1'b0;

      // Reset held two cycles, then quiet idle
      seg(2, 1, 0, 0, 3'b000, 0, 3'd0);
      seg(5, 0, 0, 0, 3'b000, 0, 3'd0);

      // Heat request held, dropped at cycle 8
      heat_cycle();

      // One-cycle cool pulse: purge aborts into overrun and lockout
      seg(1,  0, 0, 1, 3'b000, 0, 3'd1);
      seg(1,  0, 0, 0, 3'b100, 0, 3'd4);
      seg(7,  0, 0, 0, 3'b100, 0, 3'd4);
      seg(1,  0, 0, 0, 3'b100, 0, 3'd5);
      seg(15, 0, 0, 0, 3'b000, 0, 3'd5);
      seg(1,  0, 0, 0, 3'b000, 0, 3'd0);
      seg(2,  0, 0, 0, 3'b000, 0, 3'd0);

      // Both requests in IDLE: conflict per sampled cycle, no actuation
      seg(3, 0, 1, 1, 3'b000, 1, 3'd0);
      seg(1, 0, 0, 0, 3'b000, 0, 3'd0);
      seg(1, 0, 1, 1, 3'b000, 1, 3'd0);
      seg(2, 0, 0, 0, 3'b000, 0, 3'd0);

      // Cool, switch to heat mid-run: min-on, overrun, lockout, then heat start
      seg(1,  0, 0, 1, 3'b000, 0, 3'd1);
      seg(3,  0, 0, 1, 3'b100, 0, 3'd1);
      exp_sc = exp_sc + 16'd1;
      seg(1,  0, 0, 1, 3'b100, 0, 3'd3);
      seg(1,  0, 0, 1, 3'b101, 0, 3'd3);
      seg(14, 0, 1, 0, 3'b101, 0, 3'd3);
      seg(1,  0, 1, 0, 3'b101, 0, 3'd4);
      seg(7,  0, 1, 0, 3'b100, 0, 3'd4);
      seg(1,  0, 1, 0, 3'b100, 0, 3'd5);
      seg(15, 0, 1, 0, 3'b000, 0, 3'd5);
      seg(1,  0, 1, 0, 3'b000, 0, 3'd0);
      seg(1,  0, 1, 0, 3'b000, 0, 3'd1);
      seg(3,  0, 1, 0, 3'b100, 0, 3'd1);
      exp_sc = exp_sc + 16'd1;
      seg(1,  0, 1, 0, 3'b100, 0, 3'd2);
      seg(2,  0, 1, 0, 3'b110, 0, 3'd2);

      // Reset while heating: everything drops right after the reset edge
      exp_sc = 16'd0;
      seg(1, 1, 1, 0, 3'b000, 0, 3'd0);
      seg(2, 0, 0, 0, 3'b000, 0, 3'd0);

      // Two complete heat cycles after reset
      heat_cycle();
      heat_cycle();

      @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
